// File: rtl/mux_2to1.sv
// mux_2to1: registered 2:1 word selector with a capture enable and a sticky valid flag.
// Optional MUX_COMB_OUT_EN adds a zero-latency combinational out_comb port.
module mux_2to1 #(
    parameter int unsigned          WIDTH     = 10,
    parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic             sel,
    input  logic             en,
    output logic [WIDTH-1:0] out,
    output logic             out_vld
`ifdef MUX_COMB_OUT_EN
    ,
    output logic [WIDTH-1:0] out_comb
`endif
);
    logic [WIDTH-1:0] pick;

    always_comb pick = sel ? in1 : in0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out     <= RESET_VAL;
            out_vld <= 1'b0;
        end else if (en) begin
            out     <= pick;
            out_vld <= 1'b1;
        end
    end

`ifdef MUX_COMB_OUT_EN
    assign out_comb = pick;
`endif
endmodule

// File: tb/tb_mux_2to1.sv
// tb_mux_2to1: table-driven check of mux_2to1 (WIDTH=10) plus hand-written reset sequences.
module tb_mux_2to1;
    logic       clk, rst_n, sel, en;
    logic [9:0] in0, in1, out;
    logic       out_vld;
    int         checks = 0, errors = 0;
`ifdef MUX_COMB_OUT_EN
    logic [9:0] out_comb;
`endif

    mux_2to1 #(.WIDTH(10), .RESET_VAL(10'd0)) dut (
        .clk(clk), .rst_n(rst_n), .in0(in0), .in1(in1), .sel(sel), .en(en),
        .out(out), .out_vld(out_vld)
`ifdef MUX_COMB_OUT_EN
        , .out_comb(out_comb)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running required done");
        $fatal(1);
    end

    typedef struct {
        logic       en;
        logic       sel;
        logic [9:0] in0;
        logic [9:0] in1;
        logic [9:0] exp_out;
        logic       exp_vld;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_comb(input logic [9:0] exp);
`ifdef MUX_COMB_OUT_EN
        #1 chk("out_comb", out_comb, exp);
`endif
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b1, 10'd15,  10'd17,  10'd17,  1'b1};
        vecs[1]  = '{1'b1, 1'b0, 10'd15,  10'd17,  10'd15,  1'b1};
        vecs[2]  = '{1'b0, 1'b0, 10'h3FF, 10'd17,  10'd15,  1'b1};
        vecs[3]  = '{1'b0, 1'b0, 10'h3FF, 10'd17,  10'd15,  1'b1};
        vecs[4]  = '{1'b0, 1'b0, 10'h3FF, 10'd17,  10'd15,  1'b1};
        vecs[5]  = '{1'b0, 1'b0, 10'h3FF, 10'd17,  10'd15,  1'b1};
        vecs[6]  = '{1'b1, 1'b0, 10'h3FF, 10'd17,  10'h3FF, 1'b1};
        vecs[7]  = '{1'b1, 1'b1, 10'h2AA, 10'h155, 10'h155, 1'b1};
        vecs[8]  = '{1'b1, 1'b0, 10'h2AA, 10'h155, 10'h2AA, 1'b1};
        vecs[9]  = '{1'b1, 1'b1, 10'h2AA, 10'h155, 10'h155, 1'b1};
        vecs[10] = '{1'b1, 1'b0, 10'h2AA, 10'h155, 10'h2AA, 1'b1};
        vecs[11] = '{1'b0, 1'b1, 10'h2AA, 10'h155, 10'h2AA, 1'b1};
        vecs[12] = '{1'b1, 1'b0, 10'h000, 10'h3FF, 10'h000, 1'b1};
        vecs[13] = '{1'b1, 1'b1, 10'h000, 10'h3FF, 10'h3FF, 1'b1};

        rst_n = 1'b1; en = 1'b1; sel = 1'b1; in0 = 10'd15; in1 = 10'd17;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_async_out", out, 10'd0);
        chk("rst_async_vld", out_vld, 1'b0);
        chk_comb(10'd17);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_hold_out", out, 10'd0);
            chk("rst_hold_vld", out_vld, 1'b0);
        end

        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 14; i++) begin
            en = vecs[i].en; sel = vecs[i].sel; in0 = vecs[i].in0; in1 = vecs[i].in1;
            chk_comb(vecs[i].sel ? vecs[i].in1 : vecs[i].in0);
            step();
            chk($sformatf("vec%0d_out", i), out, vecs[i].exp_out);
            chk($sformatf("vec%0d_vld", i), out_vld, vecs[i].exp_vld);
        end

        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out", out, 10'd0);
        chk("mid_rst_vld", out_vld, 1'b0);
        en = 1'b1; sel = 1'b1; in1 = 10'h0AB;
        step();
        chk("mid_rst_hold_out", out, 10'd0);
        chk("mid_rst_hold_vld", out_vld, 1'b0);

        @(negedge clk);
        rst_n = 1'b1;
        en = 1'b0;
        step();
        chk("post_rst_noen_out", out, 10'd0);
        chk("post_rst_noen_vld", out_vld, 1'b0);
        en = 1'b1;
        step();
        chk("post_rst_cap_out", out, 10'h0AB);
        chk("post_rst_cap_vld", out_vld, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
